dmem_lsu: RTL and testbench

- Data-memory load/store unit directly downstream of the core's memory port (rd, wr, addr, wr_data). Consumes its read/write strobes, address, store data and funct3.
- Performs byte/halfword/word stores with byte enables into a word-organised RAM.
- Returns sign- or zero-extended load data one cycle later with a valid strobe.
- Flags misaligned or illegal accesses instead of performing them.

---
 rtl/dmem_pkg.sv | 78 +++++++
 rtl/dmem_ram.sv | 30 +++
 rtl/dmem_lsu.sv | 96 +++++++++
 tb/tb_dmem_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit:
// funct3 encodings, access sizes, byte-enable and load-extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3[1:0])
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3,
                                      input logic       is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic aligned(input size_e      sz,
                                     input logic [1:0] lane);
        logic ok;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = !lane[0];
            default: ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input size_e      sz,
                                           input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled single-port word RAM with synchronous write and registered read.
// The array is deliberately left without reset.
module dmem_ram #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: legality check, byte-enable generation, one-cycle
// load pipeline and sign/zero extension of returned data.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              access_err
);

    logic [1:0]  lane;
    size_e       sz;
    logic        ok;
    logic        st_en;
    logic        ld_en;
    logic        err_d;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic [31:0] ext;

    logic        ld_pend;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lane;
    logic        err_q;
    logic [31:0] hold;

    assign lane = addr[1:0];
    assign sz   = f3_size(funct3);
    assign ok   = f3_legal(funct3, mem_wr) && aligned(sz, lane);
    assign be   = byte_en(sz, lane);

    // A store always wins over a simultaneous load; the load is reported.
    assign st_en = mem_wr && ok && !reset;
    assign ld_en = mem_rd && !mem_wr && ok && !reset;
    assign err_d = (mem_rd && mem_wr) || ((mem_rd || mem_wr) && !ok);

    always_comb begin
        wdata = wr_data;
        case (sz)
            SZ_B:    wdata = {4{wr_data[7:0]}};
            SZ_H:    wdata = {2{wr_data[15:0]}};
            default: wdata = wr_data;
        endcase
    end

    dmem_ram #(
        .IDX_W (ADDR_W - 2)
    ) u_ram (
        .clk   (clk),
        .we    (st_en),
        .re    (ld_en),
        .be    (be),
        .idx   (addr[ADDR_W-1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    assign ext = load_ext(ram_rdata, ld_f3, ld_lane);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_pend <= 1'b0;
            ld_f3   <= 3'd0;
            ld_lane <= 2'd0;
            err_q   <= 1'b0;
            hold    <= 32'd0;
        end else begin
            ld_pend <= ld_en;
            err_q   <= err_d;
            if (ld_en) begin
                ld_f3   <= funct3;
                ld_lane <= lane;
            end
            if (ld_pend) begin
                hold <= ext;
            end
        end
    end

    // Fresh result is visible in the completion cycle, then held.
    assign rd_data    = ld_pend ? ext : hold;
    assign rd_valid   = ld_pend;
    assign access_err = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu.
// Each task drives one scenario and compares outputs inline.
module tb_dmem_lsu;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        access_err;

    int checks = 0;
    int errors = 0;

    dmem_lsu #(
        .ADDR_W (9),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .addr       (addr),
        .funct3     (funct3),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle();
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        addr    = '0;
        funct3  = 3'b000;
        wr_data = '0;
    endtask

    // Present one request for one edge; return 1 time unit after it.
    task automatic issue(input logic r, input logic w, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        mem_rd  = r;
        mem_wr  = w;
        addr    = a;
        funct3  = f;
        wr_data = d;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rd  = 1'($urandom);
            mem_wr  = 1'($urandom);
            addr    = 9'($urandom);
            funct3  = 3'($urandom);
            wr_data = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (rd_data !== 32'd0 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: data=%h valid=%b err=%b want 0/0/0",
                         rd_data, rd_valid, access_err);
            end
        end
        @(negedge clk);
        idle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rd_data !== 32'd0 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: data=%h valid=%b err=%b want 0/0/0",
                         rd_data, rd_valid, access_err);
            end
        end
    endtask

    task automatic test_word();
        issue(1'b0, 1'b1, 9'h010, 3'b010, 32'h8001_7F80);
        checks++;
        if (rd_valid !== 1'b0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_flags: valid=%b err=%b want 0/0", rd_valid, access_err);
        end
        issue(1'b1, 1'b0, 9'h010, 3'b010, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h8001_7F80) begin
            errors++;
            $display("FAIL lw: data=%h valid=%b want 80017f80/1", rd_data, rd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h8001_7F80) begin
            errors++;
            $display("FAIL lw_pulse: data=%h valid=%b want 80017f80/0", rd_data, rd_valid);
        end
    endtask

    task automatic test_subword_load();
        logic [8:0]  a [5];
        logic [2:0]  f [5];
        logic [31:0] e [5];
        a = '{9'h010, 9'h010, 9'h011, 9'h012, 9'h012};
        f = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
        e = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
              32'hFFFF_8001, 32'h0000_8001};
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b0, a[i], f[i], 32'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e[i]) begin
                errors++;
                $display("FAIL subload%0d: data=%h valid=%b want %h/1",
                         i, rd_data, rd_valid, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, 9'h020, 3'b010, 32'h0000_0000);
        issue(1'b0, 1'b1, 9'h023, 3'b000, 32'h1234_56AB);
        issue(1'b0, 1'b1, 9'h020, 3'b001, 32'hFFFF_CDEF);
        issue(1'b1, 1'b0, 9'h020, 3'b010, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hAB00_CDEF) begin
            errors++;
            $display("FAIL substore: data=%h valid=%b want ab00cdef/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_illegal();
        issue(1'b0, 1'b1, 9'h030, 3'b010, 32'h1122_3344);
        issue(1'b1, 1'b0, 9'h021, 3'b010, 32'h0);
        checks++;
        if (access_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'hAB00_CDEF) begin
            errors++;
            $display("FAIL lw_misaligned: err=%b valid=%b data=%h want 1/0/ab00cdef",
                     access_err, rd_valid, rd_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (access_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b want 0", access_err);
        end
        issue(1'b0, 1'b1, 9'h031, 3'b001, 32'h0000_FFFF);
        checks++;
        if (access_err !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL sh_misaligned: err=%b valid=%b want 1/0", access_err, rd_valid);
        end
        issue(1'b0, 1'b1, 9'h032, 3'b100, 32'h0000_5555);
        checks++;
        if (access_err !== 1'b1) begin
            errors++;
            $display("FAIL store_f3: err=%b want 1", access_err);
        end
        issue(1'b1, 1'b0, 9'h030, 3'b010, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || access_err !== 1'b0 || rd_data !== 32'h1122_3344) begin
            errors++;
            $display("FAIL illegal_nowrite: data=%h valid=%b err=%b want 11223344/1/0",
                     rd_data, rd_valid, access_err);
        end
        issue(1'b1, 1'b0, 9'h030, 3'b011, 32'h0);
        checks++;
        if (access_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h1122_3344) begin
            errors++;
            $display("FAIL load_f3: err=%b valid=%b data=%h want 1/0/11223344",
                     access_err, rd_valid, rd_data);
        end
    endtask

    task automatic test_rd_wr_both();
        issue(1'b1, 1'b1, 9'h040, 3'b010, 32'hDEAD_BEEF);
        checks++;
        if (access_err !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL both: err=%b valid=%b want 1/0", access_err, rd_valid);
        end
        issue(1'b1, 1'b0, 9'h040, 3'b010, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL both_store: data=%h valid=%b want deadbeef/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        mem_rd = 1'b1;
        addr   = 9'h040;
        funct3 = 3'b010;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_inflight: data=%h valid=%b want 0/0", rd_data, rd_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: data=%h valid=%b err=%b want 0/0/0",
                     rd_data, rd_valid, access_err);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_word();
        test_subword_load();
        test_back_to_back();
        test_illegal();
        test_rd_wr_both();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
